// File: rtl/ub_read_sequencer.sv
// ub_read_sequencer: reads a burst of unified-buffer words into a 2-entry FIFO and streams them out.
// Define UB_READ_STRIDE_EN to add a per-burst address stride input.
module ub_read_sequencer #(
    parameter int ADDRESSSIZE = 10,
    parameter int WORDSIZE    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] base_addr,
    input  logic [ADDRESSSIZE:0]   length,
`ifdef UB_READ_STRIDE_EN
    input  logic [ADDRESSSIZE-1:0] stride,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   sram_write_enable,
    output logic [ADDRESSSIZE-1:0] sram_address,
    input  logic [WORDSIZE-1:0]    sram_data_out,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WORDSIZE-1:0]    m_data,
    output logic                   m_last
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [ADDRESSSIZE-1:0] held_addr, next_addr;
    logic [ADDRESSSIZE:0]   reads_left, words_left;
    logic                   pending, head, pop, issue, accept;
    logic [1:0]             count, occ;
    logic [WORDSIZE-1:0]    fifo [2];
`ifdef UB_READ_STRIDE_EN
    logic [ADDRESSSIZE-1:0] step;
`endif

    assign pop    = m_valid & m_ready;
    assign accept = state == IDLE && start && length != '0;
    // Slots the FIFO will hold after this edge if no new read is issued now.
    assign occ    = count + 2'(pending) - 2'(pop);
    assign issue  = state == RUN && occ < 2'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? RUN : IDLE;
            RUN:     state_nxt = issue && reads_left == (ADDRESSSIZE+1)'(1) ? DRAIN : RUN;
            DRAIN:   state_nxt = pop && m_last ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy              = state != IDLE;
        sram_write_enable = 1'b0;
        sram_address      = issue ? next_addr : held_addr;
        m_valid           = count != 2'd0;
        m_last            = m_valid && words_left == (ADDRESSSIZE+1)'(1);
        m_data            = fifo[head];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_addr  <= '0;
            next_addr  <= '0;
            reads_left <= '0;
            words_left <= '0;
            pending    <= 1'b0;
            count      <= 2'd0;
            head       <= 1'b0;
            fifo[0]    <= '0;
            fifo[1]    <= '0;
            done       <= 1'b0;
`ifdef UB_READ_STRIDE_EN
            step       <= '0;
`endif
        end else begin
            done    <= (state == DRAIN && pop && m_last) || (state == IDLE && start && length == '0);
            pending <= issue;
            count   <= occ;
            if (accept) begin
                next_addr  <= base_addr;
                reads_left <= length;
                words_left <= length;
`ifdef UB_READ_STRIDE_EN
                step       <= stride;
`endif
            end
            if (issue) begin
                held_addr  <= next_addr;
                reads_left <= reads_left - (ADDRESSSIZE+1)'(1);
`ifdef UB_READ_STRIDE_EN
                next_addr  <= next_addr + step;
`else
                next_addr  <= next_addr + ADDRESSSIZE'(1);
`endif
            end
            if (pending) fifo[head ^ count[0]] <= sram_data_out;
            if (pop) begin
                head       <= ~head;
                words_left <= words_left - (ADDRESSSIZE+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_ub_read_sequencer.sv
// tb_ub_read_sequencer: randomized bursts against a queue-based model of the expected word stream.
module tb_ub_read_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, start, busy, done, sram_write_enable, m_valid, m_ready, m_last;
    logic [9:0]  base_addr, sram_address;
    logic [10:0] length;
    logic [63:0] sram_data_out, m_data;
    logic [63:0] mem [1024];

    int checks = 0;
    int errors = 0;
    int ready_pct = 100;
    logic pat [$];

    ub_read_sequencer #(.ADDRESSSIZE(10), .WORDSIZE(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
`ifdef UB_READ_STRIDE_EN
        .stride(10'd1),
`endif
        .busy(busy), .done(done), .sram_write_enable(sram_write_enable),
        .sram_address(sram_address), .sram_data_out(sram_data_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sram_data_out <= mem[sram_address];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the burst is the list of words still owed; done follows the last handshake.
    logic [63:0] q [$];
    logic        busy_m = 1'b0, done_m = 1'b0, stall = 1'b0, sl, nd;
    logic [63:0] sd;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_valid", m_valid, 0);
            chk("rst_last", m_last, 0);
            chk("rst_data", m_data, 0);
            chk("rst_addr", sram_address, 0);
            chk("rst_we", sram_write_enable, 0);
            busy_m = 1'b0;
            done_m = 1'b0;
            stall  = 1'b0;
            q.delete();
        end else begin
            chk("busy", busy, busy_m);
            chk("done", done, done_m);
            chk("we", sram_write_enable, 0);
            if (!busy_m) chk("idle_valid", m_valid, 0);
            if (m_valid && q.size() == 0) chk("extra_word", 1, 0);
            if (m_valid && q.size() > 0) begin
                chk("data", m_data, q[0]);
                chk("last", m_last, q.size() == 1);
            end
            if (stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, sd);
                chk("stall_last", m_last, sl);
            end
            stall = m_valid && !m_ready;
            sd = m_data;
            sl = m_last;
            nd = 1'b0;
            if (busy_m) begin
                if (m_valid && m_ready && q.size() > 0) begin
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        busy_m = 1'b0;
                        nd = 1'b1;
                    end
                end
            end else if (start) begin
                if (length == 0) nd = 1'b1;
                else begin
                    busy_m = 1'b1;
                    for (int k = 0; k < int'(length); k++) q.push_back(mem[(int'(base_addr) + k) % 1024]);
                end
            end
            done_m = nd;
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (pat.size() > 0) m_ready = pat.pop_front();
            else m_ready = $urandom_range(0, 99) < ready_pct;
        end
    end

    task automatic start_burst(input logic [9:0] b, input logic [10:0] l);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        length = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("burst_timeout", n < 5000, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] a0;
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = 64'(i);
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full-throughput burst with literal timing: words 4..11, done one cycle after the last.
        start_burst(10'd4, 11'd8);
        @(negedge clk);
        chk("lat_addr", sram_address, 4);
        chk("lat_v0", m_valid, 0);
        @(negedge clk);
        chk("lat_v1", m_valid, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("seq_valid", m_valid, 1);
            chk("seq_data", m_data, 64'(4 + k));
            chk("seq_last", m_last, k == 7);
        end
        @(negedge clk);
        chk("seq_done", done, 1);
        chk("seq_busy", busy, 0);
        chk("seq_vend", m_valid, 0);
        wait_idle();

        // Address wrap past the top of the buffer.
        start_burst(10'd1022, 11'd4);
        @(negedge clk);
        chk("wrap_addr0", sram_address, 1022);
        wait_idle();

        // Zero-length request: no reads, one done pulse.
        a0 = sram_address;
        start_burst(10'd100, 11'd0);
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        repeat (2) @(negedge clk);
        chk("zero_addr", sram_address, a0);
        chk("zero_done_end", done, 0);
        wait_idle();

        // Stalled stream with a fixed opening ready pattern.
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        ready_pct = 50;
        start_burst(10'($urandom_range(0, 1023)), 11'd16);
        wait_idle();

        // Reset after three words of an eight-word burst.
        ready_pct = 100;
        start_burst(10'd20, 11'd8);
        n = 0;
        while (n < 3 && checks < 1000000) begin
            @(negedge clk);
            if (m_valid && m_ready) n++;
            if (!busy) break;
        end
        chk("rst_mid_words", n, 3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_after_done", done, 0);
        start_burst(10'd0, 11'd2);
        @(negedge clk);
        @(negedge clk);
        chk("rst_new_d0", m_data, mem[0]);
        wait_idle();

        // Random bursts, random backpressure, and start pulses while busy.
        for (int b = 0; b < 12; b++) begin
            ready_pct = $urandom_range(25, 100);
            start_burst(10'($urandom_range(0, 1023)), 11'($urandom_range(1, 40)));
            if (b % 2 == 1) begin
                repeat (3) @(posedge clk);
                #1;
                if (busy) begin
                    start = 1'b1;
                    base_addr = 10'($urandom_range(0, 1023));
                    length = 11'($urandom_range(1, 40));
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ub_read_sequencer.md
UB_READ_SEQUENCER -- requirements
Module: ub_read_sequencer

Interface
REQ-001 Parameter ADDRESSSIZE, default 10: unified buffer address width.
REQ-002 Parameter WORDSIZE, default 64: word width, 8 bytes.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a burst; sampled only in IDLE.
REQ-006 base_addr  input  ADDRESSSIZE  first word address; latched on accepted start.
REQ-007 length  input  ADDRESSSIZE+1  words in burst, 0..2^ADDRESSSIZE; latched on accepted start.
REQ-008 busy  output  1  burst in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 sram_write_enable  output  1  buffer write enable; constant 0.
REQ-011 sram_address  output  ADDRESSSIZE  buffer address.
REQ-012 sram_data_out  input  WORDSIZE  buffer read data; valid one cycle after the address is presented.
REQ-013 m_valid  output  1  stream word valid.
REQ-014 m_ready  input  1  downstream accepts word.
REQ-015 m_data  output  WORDSIZE  stream word.
REQ-016 m_last  output  1  marks the final word of the burst; qualified by m_valid.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-018 IDLE->RUN SHALL occur on start=1 with length!=0; base_addr and length SHALL be latched and busy SHALL go to 1.
REQ-019 start=1 with length=0 SHALL issue no reads, SHALL leave busy at 0, and SHALL pulse done in the next cycle.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 In RUN, a read is issued in a cycle by driving sram_address; the first read SHALL use base_addr.
REQ-022 Each further read SHALL use the previous address plus 1, modulo 2^ADDRESSSIZE, so addresses wrap past the top of the buffer.
REQ-023 Each read's data SHALL be captured from sram_data_out exactly one cycle after issue into a 2-entry FIFO, tracked by a pending flag.
REQ-024 A read SHALL be issued only when (fifo_count + pending - pop) < 2, where pop = m_valid & m_ready.
REQ-025 With m_ready held at 1, the stream SHALL sustain one word per cycle.
REQ-026 For start sampled at edge N: sram_address=base_addr after edge N, the first word SHALL be captured at edge N+2, and m_valid=1 SHALL hold after edge N+2.
REQ-027 RUN->DRAIN SHALL occur when the length-th read is issued.
REQ-028 DRAIN->IDLE SHALL occur on the handshake of the word carrying m_last=1.
REQ-029 done SHALL pulse in the cycle after that handshake, and busy SHALL go to 0 together with done.
REQ-030 m_data and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-031 The FIFO SHALL never overflow or drop a word under any m_ready pattern.
REQ-032 m_last SHALL be 1 only on the length-th word.
REQ-033 When no read is issued, sram_address SHALL hold its last value.
REQ-034 sram_write_enable SHALL be 0 in every cycle.

Reset
REQ-035 On rst_n=0 the state SHALL become IDLE immediately, and the FIFO, pending flag and counters SHALL clear.
REQ-036 Reset values SHALL be: busy=0, done=0, m_valid=0, m_last=0, m_data=0, sram_address=0, sram_write_enable=0.
REQ-037 Reset during a burst SHALL abandon it: no done pulse, no further m_valid.
REQ-038 The first start after reset release SHALL behave as from a fresh IDLE.

Configuration
REQ-039 When macro UB_READ_STRIDE_EN is defined, an input stride (ADDRESSSIZE bits) SHALL be latched on start, and the address SHALL advance by stride modulo 2^ADDRESSSIZE per read.
REQ-040 When UB_READ_STRIDE_EN is undefined, the stride port SHALL not exist and the address SHALL advance by 1.

Verification
REQ-041 Buffer preloaded mem[i]=i; start, base_addr=4, length=8, m_ready=1 -> m_data 4..11 on 8 consecutive cycles, first valid 2 cycles after the start edge, m_last on 11, done one cycle later.
REQ-042 base_addr=1022, length=4 (ADDRESSSIZE=10) -> addresses 1022,1023,0,1 in order; data matches.
REQ-043 length=16, m_ready toggling 1,0,0,1 with a random stall pattern -> all 16 words delivered in order, none lost or duplicated, data stable during stalls, at most 2 reads outstanding.
REQ-044 length=0 -> no sram_address change, m_valid stays 0, one done pulse, busy stays 0.
REQ-045 rst_n pulsed low after 3 of 8 words -> outputs return to reset values at once; no done; a new start(base=0, length=2) returns mem[0], mem[1].
REQ-046 start pulsed again mid-burst -> ignored; the original burst completes unchanged.
